// File: rtl/jtag_width_conv_fifo_if.sv
// Signal bundle for jtag_width_conv_fifo: write port, read port and status flags.
// The producer/consumer side uses master, the FIFO itself uses slave.
interface jtag_width_conv_fifo_if #(
    parameter int WR_WIDTH       = 32,
    parameter int RD_WIDTH       = 1,
    parameter int WR_DEPTH_WIDTH = 6,
    parameter int RD_DEPTH_WIDTH = 11
);
    logic                      flush;
    logic [WR_WIDTH-1:0]       wr_data;
    logic                      wr_en;
    logic                      wr_full;
    logic                      almost_full;
    logic [WR_DEPTH_WIDTH:0]   wr_water_level;
    logic                      rd_en;
    logic [RD_WIDTH-1:0]       rd_data;
    logic                      rd_valid;
    logic                      rd_empty;
    logic                      almost_empty;
    logic [RD_DEPTH_WIDTH:0]   rd_water_level;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output flush, wr_data, wr_en, rd_en,
        input  wr_full, almost_full, wr_water_level, rd_data, rd_valid,
               rd_empty, almost_empty, rd_water_level, overflow, underflow
    );

    modport slave (
        input  flush, wr_data, wr_en, rd_en,
        output wr_full, almost_full, wr_water_level, rd_data, rd_valid,
               rd_empty, almost_empty, rd_water_level, overflow, underflow
    );
endinterface

// File: rtl/jtag_width_conv_fifo.sv
// Wide-write / narrow-read FIFO: each accepted write word is split into RATIO
// read units, stored unit-addressed so the read side can pop one unit per cycle.
module jtag_width_conv_fifo #(
    parameter int WR_WIDTH         = 32,
    parameter int RD_WIDTH         = 1,
    parameter int WR_DEPTH_WIDTH   = 6,
    parameter int LSB_FIRST        = 1,
    parameter int ALMOST_FULL_NUM  = 63,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input logic                   clk,
    input logic                   rst,
    jtag_width_conv_fifo_if.slave bus
);
    localparam int RATIO          = WR_WIDTH / RD_WIDTH;
    localparam int WR_DEPTH       = 1 << WR_DEPTH_WIDTH;
    localparam int RD_DEPTH       = WR_DEPTH * RATIO;
    localparam int RD_DEPTH_WIDTH = $clog2(RD_DEPTH);
    localparam int RATIO_SHIFT    = $clog2(RATIO);
    localparam int LVL_W          = RD_DEPTH_WIDTH + 1;
    localparam int WL_W           = WR_DEPTH_WIDTH + 1;

    if (RD_WIDTH < 1 || WR_WIDTH < RD_WIDTH || WR_DEPTH_WIDTH < 1 ||
        RATIO * RD_WIDTH != WR_WIDTH || (RATIO & (RATIO - 1)) != 0) begin : g_bad_widths
        $error("jtag_width_conv_fifo: WR_WIDTH/RD_WIDTH must be a power of two >= 1");
    end

    logic [RD_WIDTH-1:0]       r_mem [RD_DEPTH];
    logic [WR_DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [RD_DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [LVL_W-1:0]          r_rd_level;
    logic [WL_W-1:0]           r_wr_level;
    logic                      r_wr_full;
    logic                      r_almost_full;
    logic                      r_rd_empty;
    logic                      r_almost_empty;
    logic                      r_overflow;
    logic                      r_underflow;
    logic                      r_rd_valid;
    logic [RD_WIDTH-1:0]       r_rd_data;

    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic [LVL_W-1:0]          w_next_level;
    logic [WL_W-1:0]           w_next_wr_level;

    // Acceptance uses the flags registered at the start of the cycle; flush wins.
    always_comb begin
        w_wr_acc     = bus.wr_en & ~r_wr_full & ~bus.flush;
        w_rd_acc     = bus.rd_en & ~r_rd_empty & ~bus.flush;
        w_next_level = r_rd_level;
        if (bus.flush) begin
            w_next_level = '0;
        end else begin
            if (w_wr_acc) w_next_level = w_next_level + LVL_W'(RATIO);
            if (w_rd_acc) w_next_level = w_next_level - LVL_W'(1);
        end
        w_next_wr_level = WL_W'(w_next_level >> RATIO_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int k = 0; k < RATIO; k++) begin
                r_mem[RD_DEPTH_WIDTH'(int'(r_wr_ptr) * RATIO + k)] <= (LSB_FIRST != 0)
                    ? bus.wr_data[k*RD_WIDTH +: RD_WIDTH]
                    : bus.wr_data[(RATIO-1-k)*RD_WIDTH +: RD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rd_level     <= '0;
            r_wr_level     <= '0;
            r_wr_full      <= 1'b0;
            r_almost_full  <= 1'b0;
            r_rd_empty     <= 1'b1;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            r_rd_level     <= w_next_level;
            r_wr_level     <= w_next_wr_level;
            r_wr_full      <= int'(w_next_level) > RD_DEPTH - RATIO;
            r_rd_empty     <= w_next_level == '0;
            r_almost_full  <= int'(w_next_wr_level) >= ALMOST_FULL_NUM;
            r_almost_empty <= int'(w_next_level) <= ALMOST_EMPTY_NUM;
            if (bus.flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
                r_rd_valid  <= 1'b0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + WR_DEPTH_WIDTH'(1);
                if (w_rd_acc) begin
                    r_rd_ptr  <= r_rd_ptr + RD_DEPTH_WIDTH'(1);
                    r_rd_data <= r_mem[r_rd_ptr];
                end
                r_rd_valid <= w_rd_acc;
                if (bus.wr_en & r_wr_full)  r_overflow  <= 1'b1;
                if (bus.rd_en & r_rd_empty) r_underflow <= 1'b1;
            end
        end
    end

    assign bus.wr_full        = r_wr_full;
    assign bus.almost_full    = r_almost_full;
    assign bus.wr_water_level = r_wr_level;
    assign bus.rd_data        = r_rd_data;
    assign bus.rd_valid       = r_rd_valid;
    assign bus.rd_empty       = r_rd_empty;
    assign bus.almost_empty   = r_almost_empty;
    assign bus.rd_water_level = r_rd_level;
    assign bus.overflow       = r_overflow;
    assign bus.underflow      = r_underflow;
endmodule

// File: tb/tb_jtag_width_conv_fifo.sv
// Directed bench for jtag_width_conv_fifo: one LSB-first and one MSB-first
// instance at default sizes, driven from scenario tasks with hand-computed values.
module tb_jtag_width_conv_fifo;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    jtag_width_conv_fifo_if #(.WR_WIDTH(32), .RD_WIDTH(1), .WR_DEPTH_WIDTH(6), .RD_DEPTH_WIDTH(11)) bus_a ();
    jtag_width_conv_fifo_if #(.WR_WIDTH(32), .RD_WIDTH(1), .WR_DEPTH_WIDTH(6), .RD_DEPTH_WIDTH(11)) bus_b ();

    jtag_width_conv_fifo #(
        .WR_WIDTH(32), .RD_WIDTH(1), .WR_DEPTH_WIDTH(6), .LSB_FIRST(1),
        .ALMOST_FULL_NUM(63), .ALMOST_EMPTY_NUM(4)
    ) dut (.clk(clk), .rst(rst), .bus(bus_a.slave));

    jtag_width_conv_fifo #(
        .WR_WIDTH(32), .RD_WIDTH(1), .WR_DEPTH_WIDTH(6), .LSB_FIRST(0),
        .ALMOST_FULL_NUM(63), .ALMOST_EMPTY_NUM(4)
    ) dut_msb (.clk(clk), .rst(rst), .bus(bus_b.slave));

    function automatic logic [31:0] word_of(int i);
        return 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus_a.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b want=0", bus_a.rd_valid); end
        total++; if (bus_a.rd_data !== 1'b0) begin bad++; $display("FAIL reset_rd_data got=%0b want=0", bus_a.rd_data); end
        total++; if (bus_a.wr_full !== 1'b0) begin bad++; $display("FAIL reset_wr_full got=%0b want=0", bus_a.wr_full); end
        total++; if (bus_a.almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost_full got=%0b want=0", bus_a.almost_full); end
        total++; if (bus_a.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", bus_a.overflow); end
        total++; if (bus_a.underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%0b want=0", bus_a.underflow); end
        total++; if (bus_a.rd_empty !== 1'b1) begin bad++; $display("FAIL reset_rd_empty got=%0b want=1", bus_a.rd_empty); end
        total++; if (bus_a.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_almost_empty got=%0b want=1", bus_a.almost_empty); end
        total++; if (bus_a.rd_water_level !== 12'd0) begin bad++; $display("FAIL reset_rd_level got=%0d want=0", bus_a.rd_water_level); end
        total++; if (bus_a.wr_water_level !== 7'd0) begin bad++; $display("FAIL reset_wr_level got=%0d want=0", bus_a.wr_water_level); end
        total++; if (bus_b.rd_empty !== 1'b1) begin bad++; $display("FAIL reset_msb_rd_empty got=%0b want=1", bus_b.rd_empty); end
    endtask

    task automatic test_lsb_first();
        logic exp_bit;
        bus_a.wr_data = 32'h0000_0005;
        bus_a.wr_en   = 1'b1;
        tick();
        bus_a.wr_en = 1'b0;
        total++; if (bus_a.rd_water_level !== 12'd32) begin bad++; $display("FAIL lsb_level_after_write got=%0d want=32", bus_a.rd_water_level); end
        total++; if (bus_a.wr_water_level !== 7'd1) begin bad++; $display("FAIL lsb_wr_level got=%0d want=1", bus_a.wr_water_level); end
        bus_a.rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_bit = (i == 0 || i == 2);
            tick();
            total++;
            if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== exp_bit) begin
                bad++; $display("FAIL lsb_unit_%0d got=%0b/%0b want=1/%0b", i, bus_a.rd_valid, bus_a.rd_data, exp_bit);
            end
            if (i == 26) begin
                total++; if (bus_a.almost_empty !== 1'b0) begin bad++; $display("FAIL lsb_almost_empty_at5 got=%0b want=0", bus_a.almost_empty); end
            end
            if (i == 27) begin
                total++; if (bus_a.almost_empty !== 1'b1) begin bad++; $display("FAIL lsb_almost_empty_at4 got=%0b want=1", bus_a.almost_empty); end
            end
            if (i == 30) begin
                total++; if (bus_a.rd_empty !== 1'b0) begin bad++; $display("FAIL lsb_empty_at1 got=%0b want=0", bus_a.rd_empty); end
            end
            if (i == 31) begin
                total++; if (bus_a.rd_empty !== 1'b1) begin bad++; $display("FAIL lsb_empty_after_32 got=%0b want=1", bus_a.rd_empty); end
            end
        end
        bus_a.rd_en = 1'b0;
        tick();
        total++; if (bus_a.rd_valid !== 1'b0) begin bad++; $display("FAIL lsb_valid_idle got=%0b want=0", bus_a.rd_valid); end
    endtask

    task automatic test_msb_first();
        logic exp_bit;
        bus_b.wr_data = 32'h8000_0000;
        bus_b.wr_en   = 1'b1;
        tick();
        bus_b.wr_en = 1'b0;
        bus_b.rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_bit = (i == 0);
            tick();
            total++;
            if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== exp_bit) begin
                bad++; $display("FAIL msb_unit_%0d got=%0b/%0b want=1/%0b", i, bus_b.rd_valid, bus_b.rd_data, exp_bit);
            end
        end
        bus_b.rd_en = 1'b0;
        total++; if (bus_b.rd_empty !== 1'b1) begin bad++; $display("FAIL msb_empty_after_32 got=%0b want=1", bus_b.rd_empty); end
    endtask

    task automatic test_underflow();
        bus_a.wr_data = 32'h8000_0000;
        bus_a.wr_en   = 1'b1;
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b1;
        repeat (32) tick();
        total++; if (bus_a.rd_data !== 1'b1) begin bad++; $display("FAIL uf_last_unit got=%0b want=1", bus_a.rd_data); end
        total++; if (bus_a.underflow !== 1'b0) begin bad++; $display("FAIL uf_before got=%0b want=0", bus_a.underflow); end
        tick();
        bus_a.rd_en = 1'b0;
        total++; if (bus_a.underflow !== 1'b1) begin bad++; $display("FAIL uf_flag got=%0b want=1", bus_a.underflow); end
        total++; if (bus_a.rd_valid !== 1'b0) begin bad++; $display("FAIL uf_rd_valid got=%0b want=0", bus_a.rd_valid); end
        total++; if (bus_a.rd_data !== 1'b1) begin bad++; $display("FAIL uf_rd_data_held got=%0b want=1", bus_a.rd_data); end
        tick();
        total++; if (bus_a.underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0b want=1", bus_a.underflow); end
    endtask

    task automatic test_overflow();
        logic [31:0] got;
        int          vcount;
        do_flush();
        total++; if (bus_a.underflow !== 1'b0) begin bad++; $display("FAIL of_flush_clears_uf got=%0b want=0", bus_a.underflow); end
        bus_a.wr_en = 1'b1;
        for (int i = 0; i < 65; i++) begin
            bus_a.wr_data = word_of(i);
            tick();
            if (i == 61) begin
                total++; if (bus_a.almost_full !== 1'b0) begin bad++; $display("FAIL of_almost_full_62 got=%0b want=0", bus_a.almost_full); end
            end
            if (i == 62) begin
                total++; if (bus_a.almost_full !== 1'b1) begin bad++; $display("FAIL of_almost_full_63 got=%0b want=1", bus_a.almost_full); end
                total++; if (bus_a.wr_full !== 1'b0) begin bad++; $display("FAIL of_full_63 got=%0b want=0", bus_a.wr_full); end
            end
            if (i == 63) begin
                total++; if (bus_a.wr_full !== 1'b1) begin bad++; $display("FAIL of_full_64 got=%0b want=1", bus_a.wr_full); end
                total++; if (bus_a.wr_water_level !== 7'd64) begin bad++; $display("FAIL of_wr_level_64 got=%0d want=64", bus_a.wr_water_level); end
                total++; if (bus_a.overflow !== 1'b0) begin bad++; $display("FAIL of_overflow_early got=%0b want=0", bus_a.overflow); end
            end
            if (i == 64) begin
                total++; if (bus_a.overflow !== 1'b1) begin bad++; $display("FAIL of_overflow got=%0b want=1", bus_a.overflow); end
                total++; if (bus_a.rd_water_level !== 12'd2048) begin bad++; $display("FAIL of_rd_level got=%0d want=2048", bus_a.rd_water_level); end
            end
        end
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b1;
        for (int w = 0; w < 64; w++) begin
            got    = '0;
            vcount = 0;
            for (int b = 0; b < 32; b++) begin
                tick();
                got[b] = bus_a.rd_data;
                if (bus_a.rd_valid === 1'b1) vcount++;
            end
            total++; if (got !== word_of(w)) begin bad++; $display("FAIL of_word_%0d got=%08h want=%08h", w, got, word_of(w)); end
            total++; if (vcount != 32) begin bad++; $display("FAIL of_valid_%0d got=%0d want=32", w, vcount); end
        end
        bus_a.rd_en = 1'b0;
        total++; if (bus_a.rd_empty !== 1'b1) begin bad++; $display("FAIL of_drained_empty got=%0b want=1", bus_a.rd_empty); end
        total++; if (bus_a.overflow !== 1'b1) begin bad++; $display("FAIL of_sticky got=%0b want=1", bus_a.overflow); end
    endtask

    task automatic test_simultaneous();
        do_flush();
        bus_a.wr_data = 32'h0000_00FF;
        bus_a.wr_en   = 1'b1;
        tick();
        total++; if (bus_a.rd_water_level !== 12'd32) begin bad++; $display("FAIL sim_level_before got=%0d want=32", bus_a.rd_water_level); end
        bus_a.wr_data = 32'h1234_5678;
        bus_a.rd_en   = 1'b1;
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        total++; if (bus_a.rd_water_level !== 12'd63) begin bad++; $display("FAIL sim_rd_level got=%0d want=63", bus_a.rd_water_level); end
        total++; if (bus_a.wr_water_level !== 7'd1) begin bad++; $display("FAIL sim_wr_level got=%0d want=1", bus_a.wr_water_level); end
        total++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 1'b1) begin bad++; $display("FAIL sim_read got=%0b/%0b want=1/1", bus_a.rd_valid, bus_a.rd_data); end
    endtask

    task automatic test_flush();
        do_flush();
        bus_a.wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_a.wr_data = word_of(i);
            tick();
        end
        total++; if (bus_a.rd_water_level !== 12'd320) begin bad++; $display("FAIL fl_level_before got=%0d want=320", bus_a.rd_water_level); end
        bus_a.flush = 1'b1;
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        total++; if (bus_a.rd_water_level !== 12'd0) begin bad++; $display("FAIL fl_rd_level got=%0d want=0", bus_a.rd_water_level); end
        total++; if (bus_a.wr_water_level !== 7'd0) begin bad++; $display("FAIL fl_wr_level got=%0d want=0", bus_a.wr_water_level); end
        total++; if (bus_a.rd_empty !== 1'b1) begin bad++; $display("FAIL fl_rd_empty got=%0b want=1", bus_a.rd_empty); end
        total++; if (bus_a.overflow !== 1'b0) begin bad++; $display("FAIL fl_overflow got=%0b want=0", bus_a.overflow); end
        total++; if (bus_a.rd_valid !== 1'b0) begin bad++; $display("FAIL fl_rd_valid got=%0b want=0", bus_a.rd_valid); end
    endtask

    task automatic test_reset_mid_read();
        bus_a.wr_data = 32'hFFFF_FFFF;
        bus_a.wr_en   = 1'b1;
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b1;
        tick();
        tick();
        total++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 1'b1) begin bad++; $display("FAIL rm_reading got=%0b/%0b want=1/1", bus_a.rd_valid, bus_a.rd_data); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus_a.rd_valid !== 1'b0) begin bad++; $display("FAIL rm_rd_valid got=%0b want=0", bus_a.rd_valid); end
        total++; if (bus_a.rd_data !== 1'b0) begin bad++; $display("FAIL rm_rd_data got=%0b want=0", bus_a.rd_data); end
        total++; if (bus_a.rd_water_level !== 12'd0) begin bad++; $display("FAIL rm_rd_level got=%0d want=0", bus_a.rd_water_level); end
        total++; if (bus_a.rd_empty !== 1'b1 || bus_a.almost_empty !== 1'b1) begin bad++; $display("FAIL rm_empty_flags got=%0b/%0b want=1/1", bus_a.rd_empty, bus_a.almost_empty); end
        bus_a.rd_en = 1'b0;
        #1;
        rst = 1'b0;
        bus_a.wr_data = 32'h0000_0002;
        bus_a.wr_en   = 1'b1;
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b1;
        tick();
        total++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 1'b0) begin bad++; $display("FAIL rm_first_unit got=%0b/%0b want=1/0", bus_a.rd_valid, bus_a.rd_data); end
        tick();
        bus_a.rd_en = 1'b0;
        total++; if (bus_a.rd_data !== 1'b1) begin bad++; $display("FAIL rm_second_unit got=%0b want=1", bus_a.rd_data); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus_a.flush   = 1'b0;
        bus_a.wr_en   = 1'b0;
        bus_a.rd_en   = 1'b0;
        bus_a.wr_data = '0;
        bus_b.flush   = 1'b0;
        bus_b.wr_en   = 1'b0;
        bus_b.rd_en   = 1'b0;
        bus_b.wr_data = '0;
        #3;
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        test_lsb_first();
        test_msb_first();
        test_underflow();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtag_width_conv_fifo.md
JTAG_WIDTH_CONV_FIFO -- requirements
Module: jtag_width_conv_fifo

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 The block SHALL provide the following parameters (name, default, meaning):
- WR_WIDTH, 32, write word width in bits.
- RD_WIDTH, 1, read unit width in bits.
- WR_DEPTH_WIDTH, 6, log2 of depth in write words.
- LSB_FIRST, 1, selects the bit order of read units (1 = least significant unit first).
- ALMOST_FULL_NUM, 63, almost_full threshold in write words.
- ALMOST_EMPTY_NUM, 4, almost_empty threshold in read units.
REQ-003 The block SHALL define the derived constants RATIO = WR_WIDTH/RD_WIDTH (a power of two, at least 1), RD_DEPTH = 2^WR_DEPTH_WIDTH*RATIO and RD_DEPTH_WIDTH = log2(RD_DEPTH); any other width combination is illegal and SHALL be rejected at elaboration.
REQ-004 The block SHALL provide the following ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- flush, in, 1, synchronous clear.
- wr_data, in, WR_WIDTH, write word.
- wr_en, in, 1, write request.
- wr_full, out, 1, fewer than RATIO free read-unit slots.
- almost_full, out, 1, almost-full flag.
- wr_water_level, out, WR_DEPTH_WIDTH+1, stored read units divided by RATIO (floor).
- rd_en, in, 1, read request.
- rd_data, out, RD_WIDTH, registered read unit.
- rd_valid, out, 1, rd_data updated this cycle.
- rd_empty, out, 1, zero read units stored.
- almost_empty, out, 1, almost-empty flag.
- rd_water_level, out, RD_DEPTH_WIDTH+1, stored read units.
- overflow, out, 1, sticky flag: write rejected.
- underflow, out, 1, sticky flag: read rejected.

Function
REQ-005 A write SHALL be accepted when wr_en=1 and wr_full=0, storing RATIO read units at the write pointer.
REQ-006 A write attempted while wr_full=1 SHALL be dropped, SHALL leave storage unchanged and SHALL set overflow.
REQ-007 A read SHALL be accepted when rd_en=1 and rd_empty=0; rd_data SHALL present the unit at the read pointer on the next cycle, with rd_valid=1 for that one cycle (latency 1).
REQ-008 A read attempted while rd_empty=1 SHALL be ignored; in that case rd_valid SHALL be 0, rd_data SHALL hold its value, and underflow SHALL be set.
REQ-009 Unit ordering: with LSB_FIRST=1 the first unit read from a word SHALL be wr_data[RD_WIDTH-1:0], followed by ascending slices; with LSB_FIRST=0 the first unit SHALL be the top slice, followed by descending slices.
REQ-010 Words SHALL be read out in write order, and units within a word SHALL be read out contiguously.
REQ-011 The write pointer (in words) and the read pointer (in units) SHALL wrap modulo depth with no gap and no duplicate.
REQ-012 rd_water_level per cycle SHALL change by +RATIO for a write only, by -1 for a read only, by RATIO-1 for a simultaneous write and read, and by 0 otherwise.
REQ-013 A simultaneous write and read SHALL both be evaluated against the flags as registered at the start of the cycle.
REQ-014 wr_full SHALL equal (rd_water_level > RD_DEPTH-RATIO), and rd_empty SHALL equal (rd_water_level == 0).
REQ-015 almost_full SHALL equal (wr_water_level >= ALMOST_FULL_NUM), and almost_empty SHALL equal (rd_water_level <= ALMOST_EMPTY_NUM).
REQ-016 All flags and levels SHALL be registered and SHALL reflect the cycle's accepted operations on the following clock edge.
REQ-017 flush=1 SHALL, on the clock edge:
- zero both pointers and both levels;
- clear overflow and underflow;
- force rd_valid=0;
- take precedence over any same-cycle wr_en/rd_en, which are discarded without setting any flags.
REQ-018 With RATIO=1 the block SHALL behave as a plain synchronous FIFO of 2^WR_DEPTH_WIDTH words.

Reset
REQ-019 Asserting rst SHALL immediately force:
- both pointers and both levels to 0;
- rd_data and rd_valid to 0;
- wr_full, almost_full, overflow and underflow to 0;
- rd_empty and almost_empty to 1.
REQ-020 Asserting rst mid-operation SHALL discard all stored data; the first accepted write after deassertion SHALL be the first data read.
REQ-021 Storage contents SHALL NOT require reset.

Verification
REQ-022 The bench SHALL cover the following directed scenarios at default parameters:
- Write 0x00000005, then 32 reads -> rd_data sequence 1,0,1, then 29 zeros; rd_valid=1 for 32 cycles; rd_empty=1 after the 32nd read.
- Same stimulus with LSB_FIRST=0 and 0x80000000 -> first rd_data=1, followed by 31 zeros.
- 65 consecutive writes -> wr_full=1 and wr_water_level=64 after the 64th write; the 65th write is dropped and overflow=1; the subsequent 2048 reads return the first 64 words intact.
- With 1 word stored (rd_water_level=32), simultaneous wr_en and rd_en -> rd_water_level=63.
- rd_en while empty -> underflow=1, rd_valid=0, rd_data unchanged.
- Flush after 10 writes with wr_en=1 in the same cycle -> rd_water_level=0, rd_empty=1, overflow=0; rst asserted mid-read -> reset values appear without waiting for a clock edge.
